cic_sample_arbiter: RTL and testbench
=====================================

# cic_sample_arbiter

Collects decimated 8-bit samples from several parallel CIC decimator channels (one per sonar/magnetometer input) and serialises them onto a single tagged output stream with a valid/ready handshake. Each channel gets a one-deep holding register. A round-robin arbiter drains the holding registers into one output register. The block sits between the bank of CIC instances and the downstream sample packer/UART/FIFO, which may stall.

## Interface
Parameters:
- NUM_CH, 4, number of CIC channels (2..16)
- DATA_W, 8, sample width, matching the CIC output width
- CH_W, 2, channel-tag width; must equal ceil(log2(NUM_CH)), minimum 1

Ports:
- clk  in  1  single clock shared with the CIC bank
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_CH  per-channel one-cycle strobe; bit i is CIC i's out_valid
- in_data  in  NUM_CH*DATA_W  channel i sample on bits [i*DATA_W +: DATA_W], signed
- out_valid  out  1  output register holds a sample
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  DATA_W  sample, passed unmodified
- out_ch  out  CH_W  channel index of out_data
- overflow  out  NUM_CH  sticky per-channel overrun flags
- clear_ovf  in  1  one-cycle pulse that clears all overflow bits

## Operation
- Per channel i there are two registers: hold_i (DATA_W wide) and pend_i (1 bit).
- Capture: when in_valid[i]=1, hold_i <= in_data slice i and pend_i <= 1.
- Overrun: if in_valid[i]=1, pend_i=1, and channel i is not granted in the same cycle, then:
  - the new sample overwrites hold_i (latest sample wins);
  - overflow[i] <= 1.
- Output register "free" condition: free = !out_valid || out_ready.
- Grant: when free and any pend_i=1, select the first pending channel searching from rr_ptr upward, wrapping modulo NUM_CH.
  - Load out_data <= hold_g, out_ch <= g, out_valid <= 1, pend_g <= 0.
  - rr_ptr <= (g+1) mod NUM_CH.
- When free and no channel is pending, out_valid <= 0.
- Capture and grant on the same channel in the same cycle:
  - the output takes the old hold_g;
  - hold_g takes the new sample and pend_g stays 1;
  - no overflow is raised.
- Output stability: out_data and out_ch are held stable while out_valid && !out_ready.
- clear_ovf clears all overflow bits. If clear_ovf coincides with a new overrun on channel i, the set wins for bit i.
- Sign and width: samples are not modified, extended or truncated.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, overflow=0, all pend_i=0, all hold_i=0, rr_ptr=0.
- Reset asserted mid-transfer discards the held and pending samples. No sample is emitted for 1 cycle after reset deasserts.
- Latency: in_valid sampled at edge t sets pend at t. The sample appears on out_data with out_valid=1 after edge t+1, provided the output is free and no other channel wins.
- Throughput: one sample per cycle while out_ready=1.
- With NUM_CH simultaneous strobes and out_ready=1, all samples are emitted on consecutive cycles in round-robin order starting at rr_ptr.
- No-overflow condition: decimation ratio ≥ NUM_CH+1 and out_ready permanently 1.
- Transfer accounting: a sample completes on any edge where out_valid && out_ready. A new grant may load on that same edge (back-to-back).

## Configuration
- CIC_ARB_FIXED_PRIO_EN defined:
  - fixed priority, channel 0 highest;
  - rr_ptr is not implemented and search always starts at 0.
- CIC_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
- All ports and the remaining behaviour are identical in both builds.

## Test plan
- Reset check: assert reset for 3 cycles with in_valid=4'b1111 → out_valid=0, overflow=0 throughout. First output appears 2 cycles after the first strobe following release.
- Simultaneous strobe: in_valid=4'b1111 with data 0x11,0x22,0x33,0x44 and out_ready=1 → four consecutive outputs (ch,data) = (0,0x11), (1,0x22), (2,0x33), (3,0x44). A second burst resumes at ch 0 because rr_ptr wrapped.
- Backpressure: out_ready=0 for 10 cycles with one sample pending → out_data/out_ch stable and no loss. A second strobe on the held channel sets that channel's overflow bit, and the next emitted value from it is the newer sample.
- Same-cycle capture/grant: ch1 pending with 0x05, ch1 strobes 0x06 on the grant cycle → emits 0x05 then 0x06, overflow[1]=0.
- Clear race: overrun on ch2 in the same cycle as clear_ovf → overflow=4'b0100. clear_ovf alone on the next cycle → 4'b0000.
- Fixed-priority build: ch3 strobes every cycle and ch0 strobes once → ch0 is granted on the next free cycle, ahead of ch3.

Source files
------------

// File: rtl/cic_sample_arbiter.sv
// cic_sample_arbiter: per-channel hold registers drained round-robin (or fixed priority with CIC_ARB_FIXED_PRIO_EN) into one valid/ready output
module cic_sample_arbiter #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int CH_W   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic [NUM_CH-1:0]        overflow,
   input  logic                     clear_ovf
);
   localparam logic [CH_W:0] N = (CH_W+1)'(NUM_CH);
   logic [DATA_W-1:0] hold [NUM_CH];
   logic [NUM_CH-1:0] pend, gnt_vec;
   logic [CH_W-1:0]   base, g;
   logic [CH_W:0]     idx;
   logic              any, free, grant;
   assign free    = !out_valid || out_ready;
   assign grant   = free && any;
   assign gnt_vec = grant ? NUM_CH'(1) << g : '0;
`ifdef CIC_ARB_FIXED_PRIO_EN
   assign base = '0;
`else
   logic [CH_W-1:0] rr_ptr;
   assign base = rr_ptr;
   always_ff @(posedge clk)
      if (reset) rr_ptr <= '0;
      else if (grant) rr_ptr <= (g == CH_W'(NUM_CH-1)) ? '0 : g + 1'b1;
`endif
   // first pending channel at or after base, wrapping modulo NUM_CH
   always_comb begin
      g   = '0;
      any = 1'b0;
      idx = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = {1'b0, base} + (CH_W+1)'(k);
         idx = (idx >= N) ? idx - N : idx;
         if (!any && pend[idx[CH_W-1:0]]) begin
            g   = idx[CH_W-1:0];
            any = 1'b1;
         end
      end
   end
   // a capture on the granted channel re-arms pend; overrun only when the old sample is lost
   always_ff @(posedge clk)
      if (reset) begin
         pend     <= '0;
         overflow <= '0;
         for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid[i]) hold[i] <= in_data[i*DATA_W +: DATA_W];
            pend[i]     <= in_valid[i] | (pend[i] & ~gnt_vec[i]);
            overflow[i] <= (in_valid[i] & pend[i] & ~gnt_vec[i]) | (overflow[i] & ~clear_ovf);
         end
      end
   always_ff @(posedge clk)
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (free) begin
         out_valid <= any;
         if (any) begin
            out_data <= hold[g];
            out_ch   <= g;
         end
      end
endmodule

// File: tb/tb_cic_sample_arbiter.sv
// tb_cic_sample_arbiter: directed checks of capture, arbitration, backpressure and overflow
module tb_cic_sample_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  in_valid = '0;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic [3:0]  overflow;
   logic        clear_ovf = 1'b0;
   int checks = 0;
   int errors = 0;

   cic_sample_arbiter #(.NUM_CH(4), .DATA_W(8), .CH_W(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .overflow(overflow), .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      in_valid = 4'b1111;
      in_data = 32'h44332211;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({out_valid, overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got valid=%b ovf=%b exp 0/0000", i, out_valid, overflow);
         end
      end
      reset = 1'b0;
      in_valid = '0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got valid=%b exp 0", out_valid);
      end
      in_valid = 4'b1000;
      in_data = 32'h7F000000;
      tick();
      in_valid = '0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_lat1: got valid=%b exp 0", out_valid);
      end
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'h7F}) begin
         errors++;
         $display("FAIL reset_first_out: got v=%b ch=%0d d=%h exp 1/3/7f", out_valid, out_ch, out_data);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got valid=%b exp 0", out_valid);
      end
   endtask

   task automatic test_simultaneous(input logic [31:0] d);
      in_valid = 4'b1111;
      in_data = d;
      tick();
      in_valid = '0;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if ({out_valid, out_ch, out_data} !== {1'b1, 2'(c), d[c*8 +: 8]}) begin
            errors++;
            $display("FAIL simul_ch%0d: got v=%b ch=%0d d=%h exp 1/%0d/%h", c, out_valid, out_ch, out_data, c, d[c*8 +: 8]);
         end
      end
      tick();
      checks++;
      if ({out_valid, overflow} !== 5'b0) begin
         errors++;
         $display("FAIL simul_end: got valid=%b ovf=%b exp 0/0000", out_valid, overflow);
      end
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      in_valid = 4'b0010;
      in_data = 32'h00005A00;
      tick();
      in_valid = '0;
      tick();
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 3 || i == 6) ? 4'b0010 : 4'b0000;
         in_data = (i == 3) ? 32'h00005B00 : 32'h00005C00;
         tick();
         checks++;
         if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h5A}) begin
            errors++;
            $display("FAIL bp_stable[%0d]: got v=%b ch=%0d d=%h exp 1/1/5a", i, out_valid, out_ch, out_data);
         end
      end
      in_valid = '0;
      checks++;
      if (overflow !== 4'b0010) begin
         errors++;
         $display("FAIL bp_ovf: got %b exp 0010", overflow);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h5C}) begin
         errors++;
         $display("FAIL bp_newer: got v=%b ch=%0d d=%h exp 1/1/5c", out_valid, out_ch, out_data);
      end
      tick();
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      checks++;
      if ({out_valid, overflow} !== 5'b0) begin
         errors++;
         $display("FAIL bp_clear: got valid=%b ovf=%b exp 0/0000", out_valid, overflow);
      end
   endtask

   task automatic test_same_cycle;
      in_valid = 4'b0010;
      in_data = 32'h00000500;
      tick();
      in_data = 32'h00000600;
      tick();
      in_valid = '0;
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h05}) begin
         errors++;
         $display("FAIL same_old: got v=%b ch=%0d d=%h exp 1/1/05", out_valid, out_ch, out_data);
      end
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 8'h06}) begin
         errors++;
         $display("FAIL same_new: got v=%b ch=%0d d=%h exp 1/1/06", out_valid, out_ch, out_data);
      end
      tick();
      checks++;
      if ({out_valid, overflow} !== 5'b0) begin
         errors++;
         $display("FAIL same_ovf: got valid=%b ovf=%b exp 0/0000", out_valid, overflow);
      end
   endtask

   task automatic test_clear_race;
      logic [1:0] first_ch, second_ch;
      logic [7:0] first_d, second_d;
      out_ready = 1'b0;
      in_valid = 4'b0001;
      in_data = 32'h00000001;
      tick();
      in_valid = '0;
      tick();
      in_valid = 4'b0101;
      in_data = 32'h00200002;
      tick();
      in_valid = 4'b0001;
      in_data = 32'h00200003;
      tick();
      checks++;
      if (overflow !== 4'b0001) begin
         errors++;
         $display("FAIL race_pre: got %b exp 0001", overflow);
      end
      in_valid = 4'b0100;
      in_data = 32'h00210003;
      clear_ovf = 1'b1;
      tick();
      in_valid = '0;
      checks++;
      if (overflow !== 4'b0100) begin
         errors++;
         $display("FAIL race_set_wins: got %b exp 0100", overflow);
      end
      tick();
      clear_ovf = 1'b0;
      checks++;
      if (overflow !== 4'b0000) begin
         errors++;
         $display("FAIL race_clear: got %b exp 0000", overflow);
      end
`ifdef CIC_ARB_FIXED_PRIO_EN
      first_ch = 2'd0; first_d = 8'h03; second_ch = 2'd2; second_d = 8'h21;
`else
      first_ch = 2'd2; first_d = 8'h21; second_ch = 2'd0; second_d = 8'h03;
`endif
      out_ready = 1'b1;
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, first_ch, first_d}) begin
         errors++;
         $display("FAIL race_drain1: got v=%b ch=%0d d=%h exp 1/%0d/%h", out_valid, out_ch, out_data, first_ch, first_d);
      end
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, second_ch, second_d}) begin
         errors++;
         $display("FAIL race_drain2: got v=%b ch=%0d d=%h exp 1/%0d/%h", out_valid, out_ch, out_data, second_ch, second_d);
      end
      tick();
   endtask

   task automatic test_priority;
      in_valid = 4'b1000;
      in_data = 32'h30000000;
      tick();
      in_valid = 4'b1001;
      in_data = 32'h3100000A;
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'h30}) begin
         errors++;
         $display("FAIL prio_ch3a: got v=%b ch=%0d d=%h exp 1/3/30", out_valid, out_ch, out_data);
      end
      in_valid = 4'b1000;
      in_data = 32'h32000000;
      tick();
      checks++;
      if ({out_valid, out_ch, out_data, overflow} !== {1'b1, 2'd0, 8'h0A, 4'b1000}) begin
         errors++;
         $display("FAIL prio_ch0: got v=%b ch=%0d d=%h ovf=%b exp 1/0/0a/1000", out_valid, out_ch, out_data, overflow);
      end
      in_data = 32'h33000000;
      tick();
      in_valid = '0;
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'h32}) begin
         errors++;
         $display("FAIL prio_ch3b: got v=%b ch=%0d d=%h exp 1/3/32", out_valid, out_ch, out_data);
      end
      tick();
      checks++;
      if ({out_valid, out_ch, out_data} !== {1'b1, 2'd3, 8'h33}) begin
         errors++;
         $display("FAIL prio_ch3c: got v=%b ch=%0d d=%h exp 1/3/33", out_valid, out_ch, out_data);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      in_valid = 4'b0011;
      in_data = 32'h00004455;
      tick();
      in_valid = '0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      checks++;
      if ({out_valid, out_data, out_ch, overflow} !== 15'b0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b d=%h ch=%0d ovf=%b exp all 0", out_valid, out_data, out_ch, overflow);
      end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_discard: got valid=%b exp 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_simultaneous(32'h44332211);
      test_simultaneous(32'h7F80FF01);
      test_backpressure();
      test_same_cycle();
      test_clear_race();
      test_priority();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
